// File: rtl/stimulus_pio_pkg.sv
// Shared definitions for the stimulus PIO input port: register addresses,
// bus widths and a small bus-decode helper.
package stimulus_pio_pkg;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 32;

    // Word addresses of the slave register map
    localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_RISE_EN  = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_FALL_EN  = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_STAT = 3'd5;

    // A slave write happens when selected with the active-low strobe low
    function automatic logic bus_write(input logic chipselect, input logic write_n);
        return chipselect & ~write_n;
    endfunction

endpackage

// File: rtl/stimulus_pio_debounce.sv
// Single-bit debounce filter for the stimulus PIO input port.
// The filtered output follows the synchronised input only after the two have
// disagreed for DEBOUNCE_CYCLES consecutive cycles; shorter glitches vanish.
module stimulus_pio_debounce
#(
    parameter int DEBOUNCE_CYCLES = 16
)
(
    input  logic clk,
    input  logic reset_n,
    input  logic sync_in,
    output logic filtered
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             filt_next;

    // Count consecutive disagreeing cycles; commit the new level on the last one
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise any path that skips an assignment infers a latch.
        cnt_next  = '0;
        filt_next = filtered;
        if (sync_in != filtered) begin
            if (cnt == CNT_LAST) begin
                filt_next = sync_in;
            end else begin
                cnt_next = cnt + CNT_ONE;
            end
        end
    end

    // Counter and filtered-level state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            filtered <= 1'b0;
        end else begin
            cnt      <= cnt_next;
            filtered <= filt_next;
        end
    end

endmodule

// File: rtl/stimulus_pio_in.sv
// Parametrised parallel input port with memory-mapped slave access.
// Inputs are synchronised, optionally debounced, and per-bit rising/falling
// edges are captured into write-1-to-clear bits that drive a level irq.
// Optional feature: define STIMULUS_PIO_IN_DEBOUNCE_EN to insert a
// per-bit debounce filter of DEBOUNCE_CYCLES cycles after the synchroniser.
module stimulus_pio_in
    import stimulus_pio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16
)
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [DATA_W-1:0] readdata,
    output logic              irq
);

    logic [WIDTH-1:0]  sync_d1;
    logic [WIDTH-1:0]  sync_s;
    logic [WIDTH-1:0]  filt;
    logic [WIDTH-1:0]  prev;
    logic [WIDTH-1:0]  rise_en;
    logic [WIDTH-1:0]  fall_en;
    logic [WIDTH-1:0]  irq_mask;
    logic [WIDTH-1:0]  edge_capture;
    logic [WIDTH-1:0]  rise;
    logic [WIDTH-1:0]  fall;
    logic [WIDTH-1:0]  clr;
    logic [WIDTH-1:0]  wdata;
    logic              wr_en;
    logic [DATA_W-1:0] rd_val;
    logic              unused_bits;

    assign wr_en = bus_write(chipselect, write_n);
    assign wdata = writedata[WIDTH-1:0];

    // Two-flop synchroniser for the asynchronous pins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_d1 <= '0;
            sync_s  <= '0;
        end else begin
            // NOTE: non-blocking assignments make both flops sample the old
            // values at the same edge; blocking would collapse the chain.
            sync_d1 <= in_port;
            sync_s  <= sync_d1;
        end
    end

`ifdef STIMULUS_PIO_IN_DEBOUNCE_EN
    // One debounce filter per channel
    for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
        stimulus_pio_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk      (clk),
            .reset_n  (reset_n),
            .sync_in  (sync_s[i]),
            .filtered (filt[i])
        );
    end

    // Only the low WIDTH bits of writedata are meaningful
    assign unused_bits = ^writedata;
`else
    assign filt = sync_s;

    // Only the low WIDTH bits of writedata are meaningful; the debounce
    // length has no effect when the filter is compiled out
    assign unused_bits = ^{writedata, DEBOUNCE_CYCLES};
`endif

    // Previous filtered value for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev <= '0;
        end else begin
            prev <= filt;
        end
    end

    // Software-writable configuration registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_en  <= '1;
            fall_en  <= '1;
            irq_mask <= '0;
        end else if (wr_en) begin
            case (address)
                ADDR_RISE_EN:  rise_en  <= wdata;
                ADDR_FALL_EN:  fall_en  <= wdata;
                ADDR_IRQ_MASK: irq_mask <= wdata;
                default: ;
            endcase
        end
    end

    // Enabled edges and the write-1-to-clear mask for this cycle
    always_comb begin
        rise = filt & ~prev & rise_en;
        fall = ~filt & prev & fall_en;
        clr  = '0;
        if (wr_en && (address == ADDR_EDGE_CAP)) begin
            clr = wdata;
        end
    end

    // Edge capture bits; a new edge wins over a simultaneous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture <= '0;
        end else begin
            edge_capture <= (edge_capture & ~clr) | rise | fall;
        end
    end

    // Read multiplexer; unused upper bits and unmapped addresses read 0
    always_comb begin
        rd_val = '0;
        case (address)
            ADDR_DATA:     rd_val[WIDTH-1:0] = filt;
            ADDR_RISE_EN:  rd_val[WIDTH-1:0] = rise_en;
            ADDR_IRQ_MASK: rd_val[WIDTH-1:0] = irq_mask;
            ADDR_EDGE_CAP: rd_val[WIDTH-1:0] = edge_capture;
            ADDR_FALL_EN:  rd_val[WIDTH-1:0] = fall_en;
            ADDR_IRQ_STAT: rd_val[WIDTH-1:0] = edge_capture & irq_mask;
            default:       rd_val = '0;
        endcase
    end

    // Registered read data, refreshed every cycle from address
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_val;
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: doc/stimulus_pio_in.md
# stimulus_pio_in

Parametrised multi-bit parallel input port with a memory-mapped slave interface. It synchronises the inputs, optionally debounces them, and detects per-bit rising and/or falling edges into write-1-to-clear capture bits. It raises one level interrupt from the masked capture bits. It sits between board stimulus pins (switches, buttons, test inputs) and the system interconnect, and it is the generalised successor of the single-bit any-edge input port.

## Interface
- WIDTH, 8: number of input channels, 1..32.
- DEBOUNCE_CYCLES, 16: cycles an input must be stable before the filtered value changes, ≥1; used only when debounce is compiled in.
- clk  in  1  clock
- reset_n  in  1  reset; asynchronous, active-low
- address  in  3  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data; bits [WIDTH-1:0] used
- in_port  in  WIDTH  asynchronous external inputs
- readdata  out  32  registered read data; bits above WIDTH read 0
- irq  out  1  level interrupt, |(edge_capture & irq_mask)

## Operation
- Register map (word addresses):
  - 0 DATA, RO: filtered input value.
  - 1 RISE_EN, RW: per-bit rising-edge enable. Reset value is all ones.
  - 2 IRQ_MASK, RW: interrupt mask. Reset value is 0.
  - 3 EDGE_CAPTURE, W1C: writing a 1 clears that bit; writing a 0 leaves it unchanged.
  - 4 FALL_EN, RW: per-bit falling-edge enable. Reset value is all ones.
  - 5 IRQ_STATUS, RO: edge_capture & irq_mask.
  - 6–7: read 0; writes are ignored.
- Write occurs when chipselect=1 and write_n=0, at the clock edge.
- Sync chain: d1 <= in_port; s <= d1 (two flops per bit). Reset value is 0.
- Filtered value f:
  - With debounce compiled out, f = s.
  - Otherwise, f is the output of the debounce filter (see Configuration).
- Edge detect: a prev register tracks f (prev <= f; reset value 0).
  - rise = f & ~prev & RISE_EN
  - fall = ~f & prev & FALL_EN
- Capture update, per bit: edge_capture[i] <= (edge_capture[i] & ~clr[i]) | rise[i] | fall[i].
  - clr is the W1C write data at address 3.
  - An edge in the same cycle as a clear of that bit sets the bit: set wins.
- Defaults give any-edge capture on every bit. Writing RISE_EN=FALL_EN=0 disables capture but does not clear bits already captured.
- Changing an enable affects only edges detected after the write.
- Boundary: a pin that is high at reset release is seen as a rising edge once it reaches f, if RISE_EN is set. This is intentional.

## Timing
- Reset values:
  - readdata = 0, irq = 0, edge_capture = 0.
  - irq_mask = 0, RISE_EN = FALL_EN = all ones.
  - All sync, debounce and prev flops = 0.
- readdata is updated every clock from address, regardless of chipselect. Read latency is 1 cycle.
- Pin latency without debounce: in_port changes before edge k.
  - s updates at edge k+1.
  - edge_capture sets at edge k+2; irq rises combinationally after edge k+2.
  - DATA reflects the new value in readdata at edge k+2 if address=0 is held.
- Debounce adds DEBOUNCE_CYCLES cycles of latency.
- Register writes take effect at the write edge. irq follows mask and capture changes in the same cycle after the edge.
- Asserting reset mid-operation clears all state asynchronously. Pending captures are lost.

## Configuration
- STIMULUS_PIO_IN_DEBOUNCE_EN defined:
  - Each bit has a counter of $clog2(DEBOUNCE_CYCLES+1) bits.
  - If s[i]==f[i], the counter is set to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 while still differing, f[i] <= s[i] and the counter is set to 0.
  - Net effect: f changes only after DEBOUNCE_CYCLES consecutive disagreeing cycles. Glitches shorter than that are dropped.
- Not defined: f = s directly; the debounce logic and parameter have no effect.

## Structure
- Shared package stimulus_pio_pkg holds:
  - address constants ADDR_DATA, ADDR_RISE_EN, ADDR_IRQ_MASK, ADDR_EDGE_CAP, ADDR_FALL_EN, ADDR_IRQ_STAT;
  - ADDR_W=3.
- Sub-module stimulus_pio_debounce (one bit, parameter DEBOUNCE_CYCLES) is instantiated WIDTH times in a generate loop, only under the macro.

## Test plan
- Reset: after reset_n release, read addr 1,2,3,4 → 0xFF, 0x00, 0x00, 0xFF (WIDTH=8); irq=0.
- Rising edge: IRQ_MASK=0x01, FALL_EN=0; drive in_port[0] 0→1 → EDGE_CAPTURE=0x01 at edge k+2, irq=1. Drive 1→0 → no new capture.
- W1C with simultaneous edge: write 0x03 to addr 3 in the same cycle a new edge on bit 1 is detected → EDGE_CAPTURE=0x02 and irq stays high if bit 1 is masked.
- Mask gating: capture 0x80 with IRQ_MASK=0x00 → irq=0 and IRQ_STATUS=0. Write IRQ_MASK=0x80 → irq=1 next cycle and IRQ_STATUS=0x80.
- Debounce (macro on, DEBOUNCE_CYCLES=4): a 3-cycle pulse on bit 2 → DATA and EDGE_CAPTURE unchanged. A 6-cycle pulse → DATA bit 2 set, capture bit 2 set.
- Reset mid-operation: with EDGE_CAPTURE=0x55 and irq=1, pulse reset_n low → irq=0 immediately and all registers at reset values.
